// File: rtl/bls_data_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bls_data_server                                                          |
// | Loads one option's operands per granted request into a slot, then flags  |
// | the slot with hasUnusedData; raises OutOfData once the batch is served.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bls_data_server #(
    parameter int BSMODS       = 1,
    parameter int DATA_W       = 32,
    parameter int NUM_OPERANDS = 5,
    parameter int ADDR_W       = 10,
    parameter int OPT_W        = 8
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [OPT_W-1:0]                       option_count,
    input  logic [BSMODS-1:0]                      SERVE_REG,
    input  logic [BSMODS-1:0]                      BS_START,
    input  logic [BSMODS-1:0]                      BS_READY,
    output logic                                   rd_en,
    output logic [ADDR_W-1:0]                      rd_addr,
    input  logic [DATA_W-1:0]                      rd_data,
    output logic [BSMODS-1:0]                      hasUnusedData,
    output logic                                   OutOfData,
    output logic [BSMODS*NUM_OPERANDS*DATA_W-1:0]  opt_data,
    output logic [BSMODS*OPT_W-1:0]                opt_tag,
    output logic                                   busy
);

    localparam int c_GW = (BSMODS > 1) ? $clog2(BSMODS) : 1;
    localparam int c_KW = $clog2(NUM_OPERANDS + 1);
    localparam int c_NW = BSMODS * NUM_OPERANDS;
    localparam int c_IW = (c_NW > 1) ? $clog2(c_NW) : 1;
    localparam logic [c_GW-1:0] c_LAST_INIT = c_GW'(BSMODS - 1);
    localparam logic [c_KW-1:0] c_K_LAST    = c_KW'(NUM_OPERANDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_EMPTY = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OPT_W-1:0]    r_cnt;
    logic [OPT_W-1:0]    r_opt_idx;
    logic [ADDR_W-1:0]   r_base;
    logic [c_KW-1:0]     r_k;
    logic [c_GW-1:0]     r_g;
    logic [c_GW-1:0]     r_last_grant;
    logic [BSMODS-1:0]   r_has;
    logic [DATA_W-1:0]   r_words [c_NW];
    logic [OPT_W-1:0]    r_tags  [BSMODS];

    logic [BSMODS-1:0]   w_elig;
    logic                w_found;
    logic [c_GW-1:0]     w_gnt;
    logic                w_cap;
    logic [c_IW-1:0]     w_wr_idx;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        w_elig  = SERVE_REG & ~r_has;
        for (int off = 1; off <= BSMODS; off++) begin
            v_idx = (int'(r_last_grant) + off) % BSMODS;
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = c_GW'(v_idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        busy        = 1'b0;
        OutOfData   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (r_opt_idx == r_cnt) w_state_nxt = S_EMPTY;
                else if (w_found)       w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (r_k == c_K_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = S_ARB;
            end
            S_EMPTY: begin
                OutOfData = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign rd_addr = rd_en ? (r_base + ADDR_W'(r_k)) : '0;

    // Read data trails the address by one cycle, so word k-1 lands while k is issued;
    // in DRAIN r_k has reached NUM_OPERANDS and the same index picks the last word.
    assign w_cap    = ((r_state == S_FETCH) && (r_k != '0)) || (r_state == S_DRAIN);
    assign w_wr_idx = c_IW'(int'(r_g) * NUM_OPERANDS + int'(r_k) - 1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_opt_idx    <= '0;
            r_base       <= '0;
            r_k          <= '0;
            r_g          <= '0;
            r_last_grant <= c_LAST_INIT;
            r_has        <= '0;
            for (int i = 0; i < c_NW; i++)   r_words[i] <= '0;
            for (int i = 0; i < BSMODS; i++) r_tags[i]  <= '0;
        end else begin
            r_has <= r_has & ~(BS_START & BS_READY);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= option_count;
                        r_opt_idx <= '0;
                        r_base    <= '0;
                    end
                end
                S_ARB: begin
                    if ((r_opt_idx != r_cnt) && w_found) begin
                        r_g          <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_k          <= '0;
                    end
                end
                S_FETCH: begin
                    r_k <= r_k + 1'b1;
                end
                S_DRAIN: begin
                    r_has[r_g]  <= 1'b1;
                    r_tags[r_g] <= r_opt_idx;
                    r_opt_idx   <= r_opt_idx + 1'b1;
                    r_base      <= r_base + ADDR_W'(NUM_OPERANDS);
                end
                default: ;
            endcase
            if (w_cap) r_words[w_wr_idx] <= rd_data;
        end
    end

    assign hasUnusedData = r_has;

    generate
        for (genvar i = 0; i < BSMODS; i++) begin : g_slot
            assign opt_tag[i*OPT_W +: OPT_W] = r_tags[i];
            for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_word
                assign opt_data[(i*NUM_OPERANDS+k)*DATA_W +: DATA_W] = r_words[i*NUM_OPERANDS+k];
            end
        end
    endgenerate

endmodule
`default_nettype wire
